// File: rtl/fan_pkg.sv
// Shared FAN definitions: line control encodings and field layout helpers.
// Lines are packed as {ctrl, row, data}, with data at the LSB.
package fan_pkg;

  localparam int CTRL_W          = 4;
  localparam int CTRL_ACTIVE_BIT = 3;
  localparam int CTRL_DONE_BIT   = 2;

  localparam logic [1:0] BND_LEFT  = 2'b01;
  localparam logic [1:0] BND_RIGHT = 2'b10;
  localparam logic [1:0] BND_BOTH  = 2'b11;

  // Not active, done, both boundaries seen.
  localparam logic [CTRL_W-1:0] CTRL_COMPLETE = {1'b0, 1'b1, BND_BOTH};

  function automatic int line_row_lsb(int n_stack, int dw_data);
    return n_stack * dw_data;
  endfunction

  function automatic int line_ctrl_lsb(int n_stack, int dw_data, int dw_row);
    return n_stack * dw_data + dw_row;
  endfunction

  function automatic logic is_complete(logic [CTRL_W-1:0] ctrl);
    return (ctrl == CTRL_COMPLETE);
  endfunction

endpackage

// File: rtl/fan_lane_compactor.sv
// Prefix count of per-lane complete flags: each lane's slot offset among
// the complete lanes below it, plus the total number of complete lanes.
module fan_lane_compactor #(
  parameter int NUM_IN = 8,
  parameter int OW     = $clog2(NUM_IN) + 1
) (
  input  logic [NUM_IN-1:0]    complete_i,
  output logic [NUM_IN*OW-1:0] offset_o,
  output logic [OW-1:0]        total_o
);

  logic [OW-1:0] prefix [NUM_IN+1];

  assign prefix[0] = '0;

  genvar gi;
  for (gi = 0; gi < NUM_IN; gi++) begin : g_lane
    assign prefix[gi+1]            = prefix[gi] + OW'(complete_i[gi]);
    assign offset_o[gi*OW +: OW]   = prefix[gi];
  end

  assign total_o = prefix[NUM_IN];

endmodule

// File: rtl/fan_result_collector.sv
// FAN tree output stage: compacts complete lanes into a circular result FIFO
// and drains it over valid/ready. Optional counters via FAN_COLLECTOR_STATS_EN.
module fan_result_collector
  import fan_pkg::*;
#(
  parameter int N_STACK     = 4,
  parameter int DW_DATA     = 32,
  parameter int DW_ROW      = 4,
  parameter int DW_CTRL     = 4,
  parameter int DW_LINE     = N_STACK*DW_DATA + DW_ROW + DW_CTRL,
  parameter int NUM_IN      = 8,
  parameter int DEPTH       = 16,
  parameter int STALL_SLACK = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_IN*DW_LINE-1:0]   in,
  output logic                        stall,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [N_STACK*DW_DATA-1:0]  out_data,
  output logic [DW_ROW-1:0]           out_row,
  output logic                        overflow,
  output logic [$clog2(DEPTH):0]      count
`ifdef FAN_COLLECTOR_STATS_EN
  ,
  output logic [31:0]                 result_total,
  output logic [15:0]                 drop_total
`endif
);

  localparam int AW        = $clog2(DEPTH);
  localparam int CW        = AW + 1;
  localparam int OW        = $clog2(NUM_IN) + 1;
  localparam int DW        = line_row_lsb(N_STACK, DW_DATA);
  localparam int PW        = line_ctrl_lsb(N_STACK, DW_DATA, DW_ROW);
  localparam int STALL_THR = NUM_IN * (1 + STALL_SLACK);

  logic [PW-1:0]        mem_q [DEPTH];
  logic [CW-1:0]        wr_q, wr_d, rd_q, rd_d;
  logic                 stall_q, stall_d;
  logic                 overflow_q, overflow_d;

  logic [NUM_IN-1:0]    lane_complete;
  logic [NUM_IN-1:0]    lane_we;
  logic [PW-1:0]        lane_payload [NUM_IN];
  logic [AW-1:0]        lane_addr    [NUM_IN];
  logic [NUM_IN*OW-1:0] offset_w;
  logic [OW-1:0]        total_w;

  logic [CW-1:0]        count_w, free_w, push_n, drop_n, free_next;
  logic                 pop;
  logic [PW-1:0]        head;

  fan_lane_compactor #(
    .NUM_IN (NUM_IN),
    .OW     (OW)
  ) u_compactor (
    .complete_i (lane_complete),
    .offset_o   (offset_w),
    .total_o    (total_w)
  );

  genvar gi;
  for (gi = 0; gi < NUM_IN; gi++) begin : g_lane
    logic [OW-1:0] lane_off;
    assign lane_off          = offset_w[gi*OW +: OW];
    assign lane_complete[gi] = is_complete(in[gi*DW_LINE + PW +: DW_CTRL]);
    assign lane_payload[gi]  = in[gi*DW_LINE +: PW];
    // Lowest-indexed complete lanes win when space runs short.
    assign lane_we[gi]       = lane_complete[gi] && (CW'(lane_off) < free_w);
    assign lane_addr[gi]     = wr_q[AW-1:0] + AW'(lane_off);
  end

  // Free space is taken before this cycle's pop.
  assign count_w   = wr_q - rd_q;
  assign free_w    = CW'(DEPTH) - count_w;
  assign push_n    = (CW'(total_w) > free_w) ? free_w : CW'(total_w);
  assign drop_n    = CW'(total_w) - push_n;
  assign pop       = out_valid && out_ready;

  assign wr_d       = wr_q + push_n;
  assign rd_d       = rd_q + CW'(pop);
  assign free_next  = CW'(DEPTH) - (wr_d - rd_d);
  assign stall_d    = (32'(free_next) < 32'(STALL_THR));
  assign overflow_d = overflow_q | (drop_n != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q       <= '0;
      rd_q       <= '0;
      stall_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      stall_q    <= stall_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_IN; i++) begin
      if (!rst && lane_we[i]) begin
        mem_q[lane_addr[i]] <= lane_payload[i];
      end
    end
  end

  // Head read is combinational so a line pushed in cycle t shows in t+1.
  assign head      = mem_q[rd_q[AW-1:0]];
  assign out_valid = (count_w != '0);
  assign out_data  = out_valid ? head[DW-1:0]  : '0;
  assign out_row   = out_valid ? head[PW-1:DW] : '0;
  assign stall     = stall_q;
  assign overflow  = overflow_q;
  assign count     = count_w;

`ifdef FAN_COLLECTOR_STATS_EN
  logic [31:0] result_q;
  logic [15:0] drop_q;
  logic [16:0] drop_sum;

  assign drop_sum = {1'b0, drop_q} + 17'(drop_n);

  always_ff @(posedge clk) begin
    if (rst) begin
      result_q <= '0;
      drop_q   <= '0;
    end else begin
      result_q <= result_q + 32'(pop);
      drop_q   <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end
  end

  assign result_total = result_q;
  assign drop_total   = drop_q;
`endif

endmodule

// File: tb/tb_fan_result_collector.sv
// Directed bench for fan_result_collector with a queue-based reference model.
// Stats counters are checked when FAN_COLLECTOR_STATS_EN is defined.
module tb_fan_result_collector;

  localparam int N_STACK     = 4;
  localparam int DW_DATA     = 32;
  localparam int DW_ROW      = 4;
  localparam int DW_LINE     = 136;
  localparam int NUM_IN      = 8;
  localparam int DEPTH       = 16;
  localparam int STALL_SLACK = 2;
  localparam int PW          = 132;

  logic                      clk = 1'b0;
  logic                      rst = 1'b1;
  logic                      out_ready = 1'b0;
  logic [NUM_IN*DW_LINE-1:0] in_bus;
  logic                      stall, out_valid, overflow;
  logic [127:0]              out_data;
  logic [3:0]                out_row;
  logic [4:0]                count;
`ifdef FAN_COLLECTOR_STATS_EN
  logic [31:0]               result_total;
  logic [15:0]               drop_total;
`endif

  logic [DW_LINE-1:0] lane_v [NUM_IN];
  int checks = 0;
  int errors = 0;
  int tag    = 0;

  always #5 clk = ~clk;

  always_comb begin
    in_bus = '0;
    for (int i = 0; i < NUM_IN; i++) in_bus[i*DW_LINE +: DW_LINE] = lane_v[i];
  end

  fan_result_collector #(
    .N_STACK(N_STACK), .DW_DATA(DW_DATA), .DW_ROW(DW_ROW), .DW_CTRL(4),
    .DW_LINE(DW_LINE), .NUM_IN(NUM_IN), .DEPTH(DEPTH), .STALL_SLACK(STALL_SLACK)
  ) dut (
    .clk(clk), .rst(rst), .in(in_bus), .stall(stall),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_row(out_row), .overflow(overflow), .count(count)
`ifdef FAN_COLLECTOR_STATS_EN
    , .result_total(result_total), .drop_total(drop_total)
`endif
  );

  task automatic chk(input string nm, input logic [131:0] act, input logic [131:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a queue of {row,data} entries.
  logic [PW-1:0] mq [$];
  bit            m_ovf, m_stall, m_armed;
  int unsigned   m_results, m_drops;

  always @(negedge clk) begin
    if (rst) begin
      mq.delete();
      m_ovf = 0; m_stall = 0; m_results = 0; m_drops = 0; m_armed = 1;
    end else if (m_armed) begin
      int free, pushed;
      bit pop;
      chk("valid", out_valid, mq.size() != 0);
      chk("count", count, mq.size());
      chk("overflow", overflow, m_ovf);
      chk("stall", stall, m_stall);
      if (mq.size() != 0) begin
        chk("data", out_data, mq[0][127:0]);
        chk("row", out_row, mq[0][131:128]);
      end
`ifdef FAN_COLLECTOR_STATS_EN
      chk("result_total", result_total, m_results);
      chk("drop_total", drop_total, m_drops);
`endif
      free   = DEPTH - mq.size();
      pop    = (mq.size() != 0) && out_ready;
      pushed = 0;
      for (int i = 0; i < NUM_IN; i++) begin
        if (lane_v[i][135:132] == 4'b0111) begin
          if (pushed < free) begin
            mq.push_back(lane_v[i][131:0]);
            pushed++;
          end else begin
            m_ovf = 1;
            if (m_drops < 65535) m_drops++;
          end
        end
      end
      if (pop) begin
        void'(mq.pop_front());
        m_results++;
      end
      m_stall = (DEPTH - mq.size()) < NUM_IN * (1 + STALL_SLACK);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_lanes();
    for (int i = 0; i < NUM_IN; i++) lane_v[i] = '0;
  endtask

  task automatic set_lane(input int idx, input logic [3:0] ctrl, input logic [3:0] row);
    tag++;
    lane_v[idx] = {ctrl, row, 32'(tag*4+3), 32'(tag*4+2), 32'(tag*4+1), 32'(tag*4)};
  endtask

  task automatic push_pairs(input int cycles);
    for (int c = 0; c < cycles; c++) begin
      clear_lanes();
      set_lane(0, 4'b0111, 4'(2*c));
      set_lane(1, 4'b0111, 4'(2*c+1));
      tick();
    end
    clear_lanes();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    logic [127:0] d2, d5;
    clear_lanes();
    rst = 1; out_ready = 0;
    repeat (3) tick();
    rst = 0;
    chk("rst_valid", out_valid, 0);
    chk("rst_count", count, 0);
    chk("rst_data", out_data, 0);
    chk("rst_row", out_row, 0);
    chk("rst_stall", stall, 0);
    chk("rst_overflow", overflow, 0);

    // Lanes 2 and 5 complete, drained back to back.
    out_ready = 1;
    set_lane(2, 4'b0111, 4'd3); d2 = lane_v[2][127:0];
    set_lane(5, 4'b0111, 4'd7); d5 = lane_v[5][127:0];
    tick();
    clear_lanes();
    chk("t1_valid", out_valid, 1);
    chk("t1_row0", out_row, 3);
    chk("t1_data0", out_data, d2);
    chk("t1_count", count, 2);
    tick();
    chk("t1_row1", out_row, 7);
    chk("t1_data1", out_data, d5);
    tick();
    chk("t1_empty", out_valid, 0);

    // Non-complete ctrl values are ignored.
    for (int i = 0; i < NUM_IN; i++)
      set_lane(i, (i % 3 == 0) ? 4'b1001 : (i % 3 == 1) ? 4'b1000 : 4'b0000, 4'(i));
    tick();
    clear_lanes();
    tick();
    chk("t2_count", count, 0);

    // Two per cycle with no drain.
    out_ready = 0;
    push_pairs(5);
    chk("t3_count", count, 10);
    chk("t3_overflow", overflow, 0);
    chk("t3_stall", stall, 1);

    // Fill to 15, then three lanes with one slot left.
    push_pairs(2);
    set_lane(0, 4'b0111, 4'd9);
    tick();
    chk("t4_count15", count, 15);
    clear_lanes();
    set_lane(0, 4'b0111, 4'd10);
    set_lane(1, 4'b0111, 4'd11);
    set_lane(2, 4'b0111, 4'd12);
    tick();
    clear_lanes();
    chk("t4_count", count, 16);
    chk("t4_overflow", overflow, 1);
    tick();
    chk("t4_sticky", overflow, 1);
    out_ready = 1;
    repeat (17) tick();
    chk("t4_drained", count, 0);

    // Full FIFO: pop and push together, push is dropped.
    rst = 1; tick(); tick(); rst = 0;
    out_ready = 0;
    push_pairs(8);
    chk("t5_full", count, 16);
    chk("t5_no_ovf", overflow, 0);
    out_ready = 1;
    set_lane(4, 4'b0111, 4'd5);
    tick();
    clear_lanes();
    out_ready = 0;
    chk("t5_count", count, 15);
    chk("t5_overflow", overflow, 1);
    out_ready = 1;
    repeat (16) tick();

    // Wrap-around: offset the pointers, then two full-width bursts.
    rst = 1; tick(); rst = 0;
    for (int c = 0; c < 5; c++) begin
      set_lane(c, 4'b0111, 4'(c));
      tick();
      clear_lanes();
    end
    repeat (3) tick();
    out_ready = 0;
    for (int b = 0; b < 2; b++) begin
      for (int i = 0; i < NUM_IN; i++) set_lane(i, 4'b0111, 4'(i + 8*b));
      tick();
    end
    clear_lanes();
    chk("wrap_full", count, 16);
    out_ready = 1;
    repeat (17) tick();
    chk("wrap_drained", count, 0);

    // Statistics run: 20 accepted pops, then 4 drops, then reset mid-stream.
    rst = 1; tick(); rst = 0;
    out_ready = 1;
    for (int c = 0; c < 20; c++) begin
      set_lane(3, 4'b0111, 4'(c));
      tick();
      clear_lanes();
      tick();
    end
    out_ready = 0;
    push_pairs(8);
    for (int i = 0; i < 4; i++) set_lane(i, 4'b0111, 4'(i));
    tick();
    clear_lanes();
    tick();
    chk("st_full", count, 16);
`ifdef FAN_COLLECTOR_STATS_EN
    chk("st_results", result_total, 20);
    chk("st_drops", drop_total, 4);
`endif
    rst = 1;
    tick();
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_count", count, 0);
    chk("mid_rst_overflow", overflow, 0);
`ifdef FAN_COLLECTOR_STATS_EN
    chk("mid_rst_results", result_total, 0);
    chk("mid_rst_drops", drop_total, 0);
`endif
    rst = 0;
    tick();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
